vector_alu_pipe: RTL
====================

# vector_alu_pipe

Multi-lane, pipelined successor to the single-lane execute-stage ALU. It applies one 3-bit operation across `lanes` independent `dataSize`-bit lanes, with an optional scalar-broadcast second operand. Multiply takes a configurable multi-cycle path. A valid/ready handshake on both sides lets the execute stage stall against writeback.

## Interface
- `dataSize`, 8, lane width in bits (≥2)
- `lanes`, 4, number of parallel lanes (≥1)
- `MUL_LAT`, 2, cycles from accept to `out_valid` for multiply (≥1)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operation offered
- `in_ready`  out  1  block can accept this cycle
- `operation_select`  in  3  000 zero, 001 xor, 010 add, 011 sub, 100 mult, 101 shift right logical, 110 shift left, 111 increment
- `scalar_mode`  in  1  1: lane 0 of `operand2` is broadcast to every lane
- `operand1`, `operand2`  in  lanes*dataSize  lane i = bits [i*dataSize +: dataSize]
- `out_valid`  out  1  result registered and held
- `out_ready`  in  1  consumer takes result this cycle
- `result`  out  lanes*dataSize  per-lane result, same packing
- `neg_flag`, `zero_flag`  out  lanes  per-lane flags

## Operation
- Handshake on `in_valid & in_ready` captures `operation_select`, `scalar_mode` and both operands. Later input changes do not affect that operation.
- Per-lane arithmetic is modulo 2^dataSize, truncated to `dataSize`. Operands are unsigned.
- Increment adds 1 to `operand1` and ignores `operand2`.
- Shift amount is the full lane value of `operand2`. An amount ≥ `dataSize` yields 0.
- Mult keeps the low `dataSize` bits of the product.
- Op 000 yields result 0 on all lanes and still produces an output beat.
- Flags per lane, computed from the captured `operand1` and the final result:
  - zero = (result == 0)
  - neg = (operand1 MSB != result MSB) && !zero
- FSM states:
  - IDLE: output empty, `in_ready`=1.
  - MUL: counter runs, `in_ready`=0, `out_valid`=0.
  - HOLD: `out_valid`=1, outputs stable.
- Transitions:
  - IDLE, accept of a non-mult op → HOLD.
  - IDLE, accept of a mult op → MUL if `MUL_LAT`>1, else HOLD.
  - MUL: counter loads `MUL_LAT`-1 on accept and decrements each cycle. At 1 it writes the result and moves to HOLD.
  - HOLD: `in_ready` = `out_ready`.
  - HOLD, `out_ready`=1 with no accept → IDLE.
  - HOLD, `out_ready`=1 with an accept → HOLD or MUL, decided as from IDLE. This gives back-to-back throughput of one beat per cycle for non-mult ops.
  - HOLD, `out_ready`=0: outputs hold indefinitely and nothing is accepted.
- `result` and flags change only on the edge that enters HOLD.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state = IDLE, counter = 0.
  - `out_valid`=0, `result`=0, `neg_flag`=0, `zero_flag`=0.
  - `in_ready` is forced 0 while `rst_n` is low.
- Reset asserted during MUL or HOLD discards the operation in flight. No beat is produced for it.
- Non-mult latency: accept on edge N, `out_valid`=1 after edge N+1.
- Mult latency: accept on edge N, `out_valid`=1 after edge N+`MUL_LAT`.
- `in_ready` is combinational from state and `out_ready` only. It never depends on `in_valid`.
- `out_valid` never drops without `out_ready` having been high on the preceding edge.
- `out_ready` is ignored when `out_valid`=0.

## Test plan
- Reset then idle: assert `rst_n`=0 mid-HOLD → `out_valid`=0, `result`=0, flags 0 immediately; after release `in_ready`=1.
- Lane independence, defaults: add, `operand1`=0x01_FF_80_7F, `operand2`=0x01_01_80_01 → `result`=0x02_00_00_80.
  - `zero_flag`=0b0110.
  - `neg_flag`=0b0001: lane 0 has MSB 0→1. Lanes 1 and 2 have MSB 1→0 but are zero, so neg is masked.
  - `out_valid` one cycle after accept.
- Scalar broadcast plus shifts: lshift, `scalar_mode`=1, `operand2` lane0=3, all lanes of `operand1`=0x11 → every lane 0x88. Repeat with lane0=8 → every lane 0, `zero_flag`=0b1111.
- Multiply latency/backpressure (`MUL_LAT`=2):
  - 0x10*0x11 per lane → every lane 0x10 (low 8 bits of 0x110).
  - `in_ready`=0 during MUL; `out_valid` exactly 2 cycles after accept.
  - With `out_ready`=0 for 5 cycles, result holds and no new op is accepted.
- Streaming: `in_valid`=1 and `out_ready`=1 continuously with xor, sub, inc, op 000 → four beats on four consecutive cycles, in order.
  - The sub beat with 0x00−0x01 gives 0xFF, with `neg_flag` set.
  - Op 000 gives result 0 with all zero flags set.
- Mid-stream reset: accept a mult, drop `rst_n` for one cycle during MUL → no output beat; the next accepted op completes normally.

Source files
------------

// File: rtl/vector_alu_pipe.sv
// Purpose: multi-lane execute-stage ALU. One 3-bit op is applied to every dataSize-bit lane,
//          and lane 0 of operand2 can optionally be broadcast to all lanes.
// Latency: one cycle for non-mult ops; MUL_LAT cycles for mult (the MUL state lasts MUL_LAT-1 cycles).
// Backpressure: the result is held in HOLD until out_ready. in_ready is high in IDLE, or in HOLD
//               when out_ready is high, so non-mult ops stream at one beat per cycle.
// Ports: clk/rst_n (async active-low); in_valid/in_ready with operation_select, scalar_mode and
//        operand1/operand2 (lane i = bits [i*dataSize +: dataSize]); out_valid/out_ready with
//        result, neg_flag and zero_flag (one flag bit per lane).
module vector_alu_pipe #(
    parameter int dataSize = 8,
    parameter int lanes    = 4,
    parameter int MUL_LAT  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                operation_select,
    input  logic                      scalar_mode,
    input  logic [lanes*dataSize-1:0] operand1,
    input  logic [lanes*dataSize-1:0] operand2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [lanes*dataSize-1:0] result,
    output logic [lanes-1:0]          neg_flag,
    output logic [lanes-1:0]          zero_flag
);
    localparam int VW = lanes * dataSize;
    localparam int CW = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    state_t          state, next_state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic [VW-1:0]   a_q, b_q;
    logic [VW-1:0]   b_in;
    logic            accept, go_mul, mul_done, load_res;
    logic [2:0]      src_op;
    logic [VW-1:0]   src_a, src_b;
    logic [VW-1:0]   new_res;
    logic [lanes-1:0] new_neg, new_zero;

    // Broadcasting is folded into the captured operand, so the stored b_q already reflects scalar_mode.
    always_comb begin
        b_in = '0;
        for (int i = 0; i < lanes; i++) begin
            b_in[i*dataSize +: dataSize] = scalar_mode ? operand2[dataSize-1:0]
                                                       : operand2[i*dataSize +: dataSize];
        end
    end

    assign accept   = in_valid & in_ready;
    assign go_mul   = (operation_select == 3'b100) && (MUL_LAT > 1);
    assign mul_done = (state == MUL) && (cnt == CW'(1));
    assign load_res = (accept && !go_mul) || mul_done;

    // Single-cycle ops compute straight from the inputs on the accepting edge.
    // Mult computes from the captured copies when the counter expires.
    assign src_op = (state == MUL) ? op_q : operation_select;
    assign src_a  = (state == MUL) ? a_q  : operand1;
    assign src_b  = (state == MUL) ? b_q  : b_in;

    always_comb begin
        logic [dataSize-1:0] la, lb, lr;
        new_res  = '0;
        new_neg  = '0;
        new_zero = '0;
        for (int i = 0; i < lanes; i++) begin
            la = src_a[i*dataSize +: dataSize];
            lb = src_b[i*dataSize +: dataSize];
            case (src_op)
                3'b000:  lr = '0;
                3'b001:  lr = la ^ lb;
                3'b010:  lr = la + lb;
                3'b011:  lr = la - lb;
                3'b100:  lr = la * lb;
                3'b101:  lr = (lb >= dataSize'(dataSize)) ? '0 : (la >> lb);
                3'b110:  lr = (lb >= dataSize'(dataSize)) ? '0 : (la << lb);
                default: lr = la + dataSize'(1);
            endcase
            new_res[i*dataSize +: dataSize] = lr;
            new_zero[i] = (lr == '0);
            // A sign change is not reported when the lane result is zero.
            new_neg[i]  = (la[dataSize-1] != lr[dataSize-1]) && (lr != '0);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = go_mul ? MUL : HOLD;
            MUL:  if (cnt == CW'(1)) next_state = HOLD;
            HOLD: if (out_ready) next_state = accept ? (go_mul ? MUL : HOLD) : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic. in_ready never looks at in_valid, and it is gated low while reset is asserted.
    always_comb begin
        in_ready  = rst_n && ((state == IDLE) || ((state == HOLD) && out_ready));
        out_valid = (state == HOLD);
    end

    // Operand capture, multiply counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result    <= '0;
            neg_flag  <= '0;
            zero_flag <= '0;
        end else begin
            if (accept) begin
                op_q <= operation_select;
                a_q  <= operand1;
                b_q  <= b_in;
                if (go_mul) cnt <= CW'(MUL_LAT - 1);
            end else if (state == MUL) begin
                cnt <= cnt - CW'(1);
            end
            if (load_res) begin
                result    <= new_res;
                neg_flag  <= new_neg;
                zero_flag <= new_zero;
            end
        end
    end
endmodule
